// File: rtl/tile_blit_ctrl_if.sv
`timescale 1ns/1ps
// tile_blit_ctrl_if: renderer handshake, sprite ROM port and framebuffer write port
interface tile_blit_ctrl_if #(
    parameter int ROM_AW = 9,
    parameter int FB_AW  = 17
);
    logic              start;
    logic [8:0]        tile_x;
    logic [7:0]        tile_y;
    logic              busy;
    logic              done;
    logic [ROM_AW-1:0] rom_addr;
    logic [7:0]        rom_q;
    logic              fb_we;
    logic [FB_AW-1:0]  fb_addr;
    logic [7:0]        fb_data;
    logic              fb_ready;
    logic [8:0]        wr_count;

    modport master (
        output start, tile_x, tile_y, rom_q, fb_ready,
        input  busy, done, rom_addr, fb_we, fb_addr, fb_data, wr_count
    );

    modport slave (
        input  start, tile_x, tile_y, rom_q, fb_ready,
        output busy, done, rom_addr, fb_we, fb_addr, fb_data, wr_count
    );
endinterface

// File: rtl/tile_blit_ctrl.sv
`timescale 1ns/1ps
// tile_blit_ctrl: copies a sprite tile from ROM into the framebuffer with colour-key and clipping
module tile_blit_ctrl #(
    parameter int TILE_W    = 20,
    parameter int TILE_H    = 20,
    parameter int ROM_AW    = 9,
    parameter int FB_W      = 320,
    parameter int FB_H      = 240,
    parameter int FB_AW     = 17,
    parameter int KEY_COLOR = 255,
    parameter int KEY_EN    = 1
) (
    input logic             clock,
    input logic             resetn,
    tile_blit_ctrl_if.slave bus
);
    localparam int CW = $clog2(TILE_W);
    localparam int RW = $clog2(TILE_H);
    localparam logic [ROM_AW-1:0] LAST = ROM_AW'(TILE_W * TILE_H - 1);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

    state_t            r_state, w_next;
    logic [8:0]        r_tx;
    logic [7:0]        r_ty;
    logic [CW-1:0]     r_col, r_c1, r_cs;
    logic [RW-1:0]     r_row, r_r1, r_rs;
    logic [ROM_AW-1:0] r_rom_addr;
    logic              r_v1, r_sv;
    logic [7:0]        r_sd;
    logic              r_fb_we;
    logic [FB_AW-1:0]  r_fb_addr;
    logic [7:0]        r_fb_data;
    logic [8:0]        r_wr_count;

    logic              w_start_ok, w_stall, w_issue, w_last, w_acc, w_empty, w_wrap;
    logic              w_src_v, w_keep;
    logic [7:0]        w_src_d;
    logic [CW-1:0]     w_src_c;
    logic [RW-1:0]     w_src_r;
    logic [9:0]        w_px;
    logic [8:0]        w_py;
    logic [FB_AW-1:0]  w_fb_addr;

    assign w_start_ok = (r_state == S_IDLE) && bus.start;
    assign w_stall    = r_fb_we && !bus.fb_ready;
    assign w_acc      = r_fb_we && bus.fb_ready;
    assign w_issue    = (r_state == S_FETCH) && !w_stall;
    assign w_last     = w_issue && (r_rom_addr == LAST);
    assign w_wrap     = r_col == CW'(TILE_W - 1);
    assign w_empty    = !r_v1 && !r_sv && (!r_fb_we || bus.fb_ready);

    // A parked skid word always goes out before the word currently returning from ROM
    assign w_src_v   = r_sv || r_v1;
    assign w_src_d   = r_sv ? r_sd : bus.rom_q;
    assign w_src_c   = r_sv ? r_cs : r_c1;
    assign w_src_r   = r_sv ? r_rs : r_r1;
    assign w_px      = {1'b0, r_tx} + 10'(w_src_c);
    assign w_py      = {1'b0, r_ty} + 9'(w_src_r);
    assign w_keep    = !(KEY_EN != 0 && w_src_d == 8'(KEY_COLOR)) && (w_px < 10'(FB_W)) && (w_py < 9'(FB_H));
    assign w_fb_addr = FB_AW'(w_py) * FB_AW'(FB_W) + FB_AW'(w_px);

    assign bus.busy     = r_state != S_IDLE;
    assign bus.done     = r_state == S_DONE;
    assign bus.rom_addr = r_rom_addr;
    assign bus.fb_we    = r_fb_we;
    assign bus.fb_addr  = r_fb_addr;
    assign bus.fb_data  = r_fb_data;
    assign bus.wr_count = r_wr_count;

    // State register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    // Next-state: start only honoured in IDLE, DONE always lasts one cycle
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = bus.start ? S_FETCH : S_IDLE;
            S_FETCH: w_next = w_last ? S_DRAIN : S_FETCH;
            S_DRAIN: w_next = w_empty ? S_DONE : S_DRAIN;
            default: w_next = S_IDLE;
        endcase
    end

    // Tile origin latch and linear ROM address / row / col sequencer
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_tx       <= '0;
            r_ty       <= '0;
            r_col      <= '0;
            r_row      <= '0;
            r_rom_addr <= '0;
        end else if (w_start_ok) begin
            r_tx       <= bus.tile_x;
            r_ty       <= bus.tile_y;
            r_col      <= '0;
            r_row      <= '0;
            r_rom_addr <= '0;
        end else if (w_issue) begin
            r_rom_addr <= w_last ? '0 : r_rom_addr + 1'b1;
            r_col      <= w_wrap ? '0 : r_col + 1'b1;
            r_row      <= w_last ? '0 : (w_wrap ? r_row + 1'b1 : r_row);
        end
    end

    // ROM-return tracking, one-entry skid on the first stall cycle, registered write port
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_v1      <= 1'b0;
            r_c1      <= '0;
            r_r1      <= '0;
            r_sv      <= 1'b0;
            r_sd      <= '0;
            r_cs      <= '0;
            r_rs      <= '0;
            r_fb_we   <= 1'b0;
            r_fb_addr <= '0;
            r_fb_data <= '0;
        end else begin
            r_v1 <= w_issue;
            r_c1 <= r_col;
            r_r1 <= r_row;
            if (w_stall) begin
                if (r_v1) begin
                    r_sv <= 1'b1;
                    r_sd <= bus.rom_q;
                    r_cs <= r_c1;
                    r_rs <= r_r1;
                end
            end else begin
                r_sv    <= 1'b0;
                r_fb_we <= w_src_v && w_keep;
                if (w_src_v) begin
                    r_fb_addr <= w_fb_addr;
                    r_fb_data <= w_src_d;
                end
            end
        end
    end

    // Accepted-write counter, cleared when a new blit starts
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)         r_wr_count <= '0;
        else if (w_start_ok) r_wr_count <= '0;
        else if (w_acc)      r_wr_count <= r_wr_count + 1'b1;
    end
endmodule

// File: tb/tb_tile_blit_ctrl.sv
`timescale 1ns/1ps
// tb_tile_blit_ctrl: directed scenarios for the tile blitter against a behavioural ROM and reference pixel list
module tb_tile_blit_ctrl;
    logic clock = 1'b0;
    logic resetn = 1'b1;
    always #5 clock = ~clock;

    tile_blit_ctrl_if #(.ROM_AW(9), .FB_AW(17)) bus();
    tile_blit_ctrl dut (.clock(clock), .resetn(resetn), .bus(bus));

    logic [7:0] rom_mem [0:399];

    // Synchronous sprite ROM, one cycle read latency
    always @(posedge clock) bus.rom_q <= (bus.rom_addr < 9'd400) ? rom_mem[bus.rom_addr] : 8'h00;

    int n_vec = 0;
    int n_err = 0;
    int wa[$], wd[$], wc[$], ea[$], ed[$];
    int done_cyc, done_pulses, unstable, busy_c1, addr_c1, addr_c2, busy_after;

    // Reference: row-major tile order, key colour skipped, off-screen pixels clipped
    task automatic model(input int x, input int y);
        int d;
        ea.delete();
        ed.delete();
        for (int r = 0; r < 20; r++)
            for (int c = 0; c < 20; c++) begin
                d = int'(rom_mem[r*20+c]);
                if (d != 255 && x + c < 320 && y + r < 240) begin
                    ea.push_back((y + r) * 320 + x + c);
                    ed.push_back(d);
                end
            end
    endtask

    task automatic fill_rom(input int mode);
        for (int i = 0; i < 400; i++)
            rom_mem[i] = (mode == 0) ? 8'd162 : (mode == 1) ? ((i == 7) ? 8'd162 : 8'd255) : 8'(i % 256);
    endtask

    // Runs one blit, recording accepted writes with their cycle numbers
    task automatic blit(input int x, input int y, input bit rnd, input bit poke);
        logic pstall;
        int pa, pd;
        wa.delete(); wd.delete(); wc.delete();
        done_cyc = -1; done_pulses = 0; unstable = 0; busy_after = -1;
        pstall = 1'b0; pa = 0; pd = 0;
        @(negedge clock);
        bus.tile_x = 9'(x);
        bus.tile_y = 8'(y);
        bus.start = 1'b1;
        bus.fb_ready = 1'b1;
        for (int c = 1; c < 4000; c++) begin
            @(negedge clock);
            bus.start = poke && (c == 50 || (done_cyc < 0 && bus.done === 1'b1));
            if (pstall && (bus.fb_we !== 1'b1 || int'(bus.fb_addr) != pa || int'(bus.fb_data) != pd)) unstable++;
            bus.fb_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bus.fb_we === 1'b1 && bus.fb_ready) begin
                wa.push_back(int'(bus.fb_addr));
                wd.push_back(int'(bus.fb_data));
                wc.push_back(c);
            end
            pstall = (bus.fb_we === 1'b1) && !bus.fb_ready;
            pa = int'(bus.fb_addr);
            pd = int'(bus.fb_data);
            if (c == 1) begin
                busy_c1 = int'(bus.busy);
                addr_c1 = int'(bus.rom_addr);
            end
            if (c == 2) addr_c2 = int'(bus.rom_addr);
            if (bus.done === 1'b1) begin
                done_pulses++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (done_cyc >= 0 && c == done_cyc + 1) begin
                busy_after = int'(bus.busy);
                break;
            end
        end
        bus.start = 1'b0;
        bus.fb_ready = 1'b1;
    endtask

    task automatic test_reset;
        bus.start = 1'b0; bus.tile_x = '0; bus.tile_y = '0; bus.fb_ready = 1'b1;
        #2 resetn = 1'b0;
        repeat (3) @(negedge clock);
        n_vec++;
        if ({bus.busy, bus.done, bus.fb_we, bus.rom_addr, bus.fb_addr, bus.fb_data, bus.wr_count} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs got busy=%b done=%b we=%b ra=%0d fa=%0d fd=%0d wc=%0d want all 0",
                     bus.busy, bus.done, bus.fb_we, bus.rom_addr, bus.fb_addr, bus.fb_data, bus.wr_count);
        end
        resetn = 1'b1;
        repeat (2) @(negedge clock);
        n_vec++;
        if (bus.busy !== 1'b0 || bus.rom_addr !== 9'd0) begin
            n_err++;
            $display("FAIL idle_after_reset got busy=%b rom_addr=%0d want 0/0", bus.busy, bus.rom_addr);
        end
    endtask

    task automatic test_full;
        fill_rom(0);
        model(0, 0);
        blit(0, 0, 1'b0, 1'b0);
        n_vec++; if (busy_c1 != 1) begin n_err++; $display("FAIL t1_busy_c1 got %0d want 1", busy_c1); end
        n_vec++; if (addr_c1 != 0) begin n_err++; $display("FAIL t1_rom_addr_c1 got %0d want 0", addr_c1); end
        n_vec++; if (addr_c2 != 1) begin n_err++; $display("FAIL t1_rom_addr_c2 got %0d want 1", addr_c2); end
        n_vec++; if (done_cyc != 403) begin n_err++; $display("FAIL t1_done_cycle got %0d want 403", done_cyc); end
        n_vec++; if (done_pulses != 1) begin n_err++; $display("FAIL t1_done_pulses got %0d want 1", done_pulses); end
        n_vec++; if (busy_after != 0) begin n_err++; $display("FAIL t1_busy_404 got %0d want 0", busy_after); end
        n_vec++;
        if (wc.size() != 400 || wc[0] != 3 || wc[wc.size()-1] != 402) begin
            n_err++;
            $display("FAIL t1_write_window got n=%0d first=%0d last=%0d want 400/3/402",
                     wc.size(), wc.size() ? wc[0] : -1, wc.size() ? wc[wc.size()-1] : -1);
        end
        n_vec++; if (wa.size() != ea.size()) begin n_err++; $display("FAIL t1_count got %0d want %0d", wa.size(), ea.size()); end
        for (int i = 0; i < ea.size() && i < wa.size(); i++) begin
            n_vec++;
            if (wa[i] != ea[i] || wd[i] != ed[i]) begin
                n_err++;
                $display("FAIL t1_pix[%0d] got %0d/%0d want %0d/%0d", i, wa[i], wd[i], ea[i], ed[i]);
            end
        end
        n_vec++; if (bus.wr_count !== 9'd400) begin n_err++; $display("FAIL t1_wr_count got %0d want 400", bus.wr_count); end
    endtask

    task automatic test_key;
        fill_rom(1);
        blit(100, 50, 1'b0, 1'b0);
        n_vec++;
        if (wa.size() != 1 || wa[0] != 16107 || wd[0] != 162) begin
            n_err++;
            $display("FAIL t2_single got n=%0d addr=%0d data=%0d want 1/16107/162",
                     wa.size(), wa.size() ? wa[0] : -1, wd.size() ? wd[0] : -1);
        end
        n_vec++; if (bus.wr_count !== 9'd1) begin n_err++; $display("FAIL t2_wr_count got %0d want 1", bus.wr_count); end
        n_vec++; if (done_cyc != 403) begin n_err++; $display("FAIL t2_done_cycle got %0d want 403", done_cyc); end
    endtask

    task automatic test_clip;
        fill_rom(0);
        model(310, 230);
        blit(310, 230, 1'b0, 1'b0);
        n_vec++; if (bus.wr_count !== 9'd100) begin n_err++; $display("FAIL t3_wr_count got %0d want 100", bus.wr_count); end
        n_vec++; if (wa.size() == 0 || wa[0] != 73910) begin n_err++; $display("FAIL t3_first_addr got %0d want 73910", wa.size() ? wa[0] : -1); end
        n_vec++; if (wa.size() != ea.size()) begin n_err++; $display("FAIL t3_count got %0d want %0d", wa.size(), ea.size()); end
        for (int i = 0; i < ea.size() && i < wa.size(); i++) begin
            n_vec++;
            if (wa[i] != ea[i] || wd[i] != ed[i]) begin
                n_err++;
                $display("FAIL t3_pix[%0d] got %0d/%0d want %0d/%0d", i, wa[i], wd[i], ea[i], ed[i]);
            end
        end
    endtask

    task automatic test_backpressure;
        fill_rom(2);
        model(5, 7);
        blit(5, 7, 1'b1, 1'b0);
        n_vec++; if (done_cyc < 0) begin n_err++; $display("FAIL t4_done_timeout got %0d want completion", done_cyc); end
        n_vec++; if (unstable != 0) begin n_err++; $display("FAIL t4_stall_hold got %0d changes want 0", unstable); end
        n_vec++; if (wa.size() != ea.size()) begin n_err++; $display("FAIL t4_count got %0d want %0d", wa.size(), ea.size()); end
        n_vec++; if (int'(bus.wr_count) != ea.size()) begin n_err++; $display("FAIL t4_wr_count got %0d want %0d", bus.wr_count, ea.size()); end
        for (int i = 0; i < ea.size() && i < wa.size(); i++) begin
            n_vec++;
            if (wa[i] != ea[i] || wd[i] != ed[i]) begin
                n_err++;
                $display("FAIL t4_pix[%0d] got %0d/%0d want %0d/%0d", i, wa[i], wd[i], ea[i], ed[i]);
            end
        end
    endtask

    task automatic test_start_ignored;
        int extra;
        fill_rom(0);
        model(40, 60);
        blit(40, 60, 1'b0, 1'b1);
        n_vec++; if (done_cyc != 403) begin n_err++; $display("FAIL t5_done_cycle got %0d want 403", done_cyc); end
        n_vec++; if (busy_after != 0) begin n_err++; $display("FAIL t5_busy_after_done got %0d want 0", busy_after); end
        n_vec++; if (wa.size() != ea.size()) begin n_err++; $display("FAIL t5_count got %0d want %0d", wa.size(), ea.size()); end
        for (int i = 0; i < ea.size() && i < wa.size(); i++) begin
            n_vec++;
            if (wa[i] != ea[i] || wd[i] != ed[i]) begin
                n_err++;
                $display("FAIL t5_pix[%0d] got %0d/%0d want %0d/%0d", i, wa[i], wd[i], ea[i], ed[i]);
            end
        end
        extra = 0;
        repeat (20) begin
            @(negedge clock);
            if (bus.busy !== 1'b0 || bus.fb_we !== 1'b0) extra++;
        end
        n_vec++; if (extra != 0) begin n_err++; $display("FAIL t5_second_blit got %0d active cycles want 0", extra); end
        n_vec++; if (bus.wr_count !== 9'd400) begin n_err++; $display("FAIL t5_wr_count got %0d want 400", bus.wr_count); end
    endtask

    task automatic test_reset_mid;
        int act;
        fill_rom(2);
        @(negedge clock);
        bus.tile_x = 9'd0; bus.tile_y = 8'd0; bus.start = 1'b1; bus.fb_ready = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        repeat (149) @(negedge clock);
        n_vec++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL t6_busy_mid got %b want 1", bus.busy); end
        resetn = 1'b0;
        #1;
        n_vec++;
        if ({bus.busy, bus.done, bus.fb_we, bus.rom_addr, bus.fb_addr, bus.fb_data, bus.wr_count} !== '0) begin
            n_err++;
            $display("FAIL t6_async_reset got busy=%b we=%b ra=%0d fa=%0d fd=%0d wc=%0d want all 0",
                     bus.busy, bus.fb_we, bus.rom_addr, bus.fb_addr, bus.fb_data, bus.wr_count);
        end
        repeat (3) @(negedge clock);
        resetn = 1'b1;
        act = 0;
        repeat (20) begin
            @(negedge clock);
            if (bus.fb_we !== 1'b0 || bus.busy !== 1'b0) act++;
        end
        n_vec++; if (act != 0) begin n_err++; $display("FAIL t6_quiet_after_reset got %0d active cycles want 0", act); end
        model(20, 10);
        blit(20, 10, 1'b0, 1'b0);
        n_vec++; if (done_cyc != 403) begin n_err++; $display("FAIL t6_done_cycle got %0d want 403", done_cyc); end
        n_vec++; if (wa.size() != ea.size()) begin n_err++; $display("FAIL t6_count got %0d want %0d", wa.size(), ea.size()); end
        n_vec++; if (int'(bus.wr_count) != ea.size()) begin n_err++; $display("FAIL t6_wr_count got %0d want %0d", bus.wr_count, ea.size()); end
        for (int i = 0; i < ea.size() && i < wa.size(); i++) begin
            n_vec++;
            if (wa[i] != ea[i] || wd[i] != ed[i]) begin
                n_err++;
                $display("FAIL t6_pix[%0d] got %0d/%0d want %0d/%0d", i, wa[i], wd[i], ea[i], ed[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_full();
        test_key();
        test_clip();
        test_backpressure();
        test_start_ignored();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
